// File: rtl/alarm_pkg.sv
// Shared types and default timing for the alarm buzzer driver: state encoding,
// default cadence constants and the escalation threshold.
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BEEP_ON  = 3'd1,
        BEEP_OFF = 3'd2,
        PAUSE    = 3'd3,
        SILENCED = 3'd4
    } state_e;

    localparam int DEF_TONE_DIV     = 2;
    localparam int DEF_ON_CYCLES    = 8;
    localparam int DEF_OFF_CYCLES   = 8;
    localparam int DEF_BURSTS       = 3;
    localparam int DEF_PAUSE_CYCLES = 32;

    // Completed patterns after which the tone becomes continuous.
    localparam int ESC_THRESHOLD = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarm_beeper_if.sv
// Signal bundle between the alarm controller (master) and the buzzer driver (slave).
interface alarm_beeper_if;
    logic       alert_i;
    logic       ack_i;
    logic       buzzer_o;
    logic       active_o;
    logic       silenced_o;
    logic [3:0] beep_count_o;

    modport master (
        output alert_i, ack_i,
        input  buzzer_o, active_o, silenced_o, beep_count_o
    );

    modport slave (
        input  alert_i, ack_i,
        output buzzer_o, active_o, silenced_o, beep_count_o
    );
endinterface

// File: rtl/beeper_tone_gen.sv
// Square-wave tone source: high/low every TONE_DIV cycles while enabled,
// restarts high on restart, held low when disabled.
module beeper_tone_gen #(
    parameter int TONE_DIV = alarm_pkg::DEF_TONE_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tone
);

    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(TONE_DIV - 1);

    logic [TW-1:0] cnt_q;
    logic          tone_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else if (restart) begin
            cnt_q  <= RELOAD;
            tone_q <= 1'b1;
        end else if (!en) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q  <= RELOAD;
            tone_q <= ~tone_q;
        end else begin
            cnt_q  <= cnt_q - 1'b1;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/alarm_beeper.sv
// Alarm buzzer driver: cadenced beep bursts while alert is high, silenced by ack.
// Optional escalation to a continuous tone: define ALARM_BEEPER_ESCALATE_EN.
module alarm_beeper
    import alarm_pkg::*;
#(
    parameter int TONE_DIV     = DEF_TONE_DIV,
    parameter int ON_CYCLES    = DEF_ON_CYCLES,
    parameter int OFF_CYCLES   = DEF_OFF_CYCLES,
    parameter int BURSTS       = DEF_BURSTS,
    parameter int PAUSE_CYCLES = DEF_PAUSE_CYCLES
) (
    input  logic           clk,
    input  logic           rst_n,
    alarm_beeper_if.slave  bus
);

    localparam int PH_MAX = max3(ON_CYCLES, OFF_CYCLES, PAUSE_CYCLES);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] ON_LD    = PH_W'(ON_CYCLES - 1);
    localparam logic [PH_W-1:0] OFF_LD   = PH_W'(OFF_CYCLES - 1);
    localparam logic [PH_W-1:0] PAUSE_LD = PH_W'(PAUSE_CYCLES - 1);
    localparam logic [3:0]      BURSTS4  = 4'(BURSTS);

    state_e          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [3:0]      count_q, count_d;
    logic [3:0]      count_inc;
    logic            active_q, silenced_q;
    logic            tone_en, tone_restart;
    logic            escalated;

`ifdef ALARM_BEEPER_ESCALATE_EN
    logic [2:0] pat_q, pat_d;
    assign escalated = (pat_q >= 3'(ESC_THRESHOLD));
`else
    assign escalated = 1'b0;
`endif

    assign count_inc = count_q + 4'd1;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
`ifdef ALARM_BEEPER_ESCALATE_EN
        pat_d   = pat_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.alert_i) begin
                    state_d = BEEP_ON;
                    phase_d = ON_LD;
                    count_d = '0;
                end
            end
            SILENCED: begin
                if (!bus.alert_i) state_d = IDLE;
            end
            BEEP_ON, BEEP_OFF, PAUSE: begin
                // Alert drop outranks ack, and both outrank phase expiry.
                if (!bus.alert_i || bus.ack_i) begin
                    state_d = bus.alert_i ? SILENCED : IDLE;
                    phase_d = '0;
                    count_d = '0;
                end else if (phase_q != '0) begin
                    phase_d = phase_q - 1'b1;
                end else if (state_q == BEEP_ON) begin
                    count_d = (count_inc >= BURSTS4) ? BURSTS4 : count_inc;
                    if (escalated) begin
                        phase_d = ON_LD;
                    end else if (count_inc >= BURSTS4) begin
                        state_d = PAUSE;
                        phase_d = PAUSE_LD;
                    end else begin
                        state_d = BEEP_OFF;
                        phase_d = OFF_LD;
                    end
                end else begin
                    state_d = BEEP_ON;
                    phase_d = ON_LD;
                    if (state_q == PAUSE) begin
                        count_d = '0;
`ifdef ALARM_BEEPER_ESCALATE_EN
                        if (pat_q != 3'd7) pat_d = pat_q + 3'd1;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                count_d = '0;
            end
        endcase
`ifdef ALARM_BEEPER_ESCALATE_EN
        if (state_d == IDLE || state_d == SILENCED) pat_d = '0;
`endif
    end

    // Tone phase restarts high on every beep entry, including back-to-back beeps.
    assign tone_en      = (state_d == BEEP_ON);
    assign tone_restart = tone_en && ((state_q != BEEP_ON) || (phase_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            count_q    <= '0;
            active_q   <= 1'b0;
            silenced_q <= 1'b0;
`ifdef ALARM_BEEPER_ESCALATE_EN
            pat_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            count_q    <= count_d;
            active_q   <= (state_d == BEEP_ON) || (state_d == BEEP_OFF) || (state_d == PAUSE);
            silenced_q <= (state_d == SILENCED);
`ifdef ALARM_BEEPER_ESCALATE_EN
            pat_q      <= pat_d;
`endif
        end
    end

    beeper_tone_gen #(.TONE_DIV(TONE_DIV)) u_tone (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (tone_en),
        .restart (tone_restart),
        .tone    (bus.buzzer_o)
    );

    assign bus.active_o     = active_q;
    assign bus.silenced_o   = silenced_q;
    assign bus.beep_count_o = count_q;

endmodule

// File: doc/alarm_beeper.md
Name: alarm_beeper

Overview:
Drives the buzzer pin from the alarm controller's alert level.
- While alert is asserted, emits a cadenced tone pattern: BURSTS beeps of a square-wave tone, each separated by a gap, then a long pause; the pattern repeats.
- An acknowledge input silences the buzzer until the alert drops.
- Sits between the alarm FSM output (uo_out[0]) and the physical buzzer pin.

Parameters:
- TONE_DIV, 2, tone half-period in clk cycles (>=1)
- ON_CYCLES, 8, clk cycles per beep (tone active)
- OFF_CYCLES, 8, clk cycles of silence between beeps
- BURSTS, 3, beeps per pattern (1..15)
- PAUSE_CYCLES, 32, silent clk cycles after the last beep of a pattern

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- alert_i  input  1  alarm level from the alarm FSM; synchronous to clk
- ack_i  input  1  cleaned, active-high single-cycle acknowledge pulse
- buzzer_o  output  1  tone output to the pin
- active_o  output  1  high while the pattern is running
- silenced_o  output  1  high while acknowledged and alert still high
- beep_count_o  output  4  beeps completed in the current pattern

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; all counters 0.
- States: IDLE, BEEP_ON, BEEP_OFF, PAUSE, SILENCED. All outputs are registered.
- IDLE:
  - If alert_i=1 at an edge, go to BEEP_ON.
  - ack_i is ignored.
- BEEP_ON:
  - Lasts exactly ON_CYCLES cycles.
  - buzzer_o=1 from the entry edge, so there is 1 cycle of latency from the alert_i sampling edge.
  - buzzer_o toggles every TONE_DIV cycles: high TONE_DIV cycles, then low TONE_DIV cycles, and so on.
  - On the last cycle, beep_count_o increments. If the new count equals BURSTS, go to PAUSE; otherwise go to BEEP_OFF.
- BEEP_OFF:
  - buzzer_o=0 for OFF_CYCLES cycles, then BEEP_ON.
  - The tone phase restarts high on each BEEP_ON entry.
- PAUSE:
  - buzzer_o=0 for PAUSE_CYCLES cycles.
  - Then beep_count_o clears to 0 and the FSM goes to BEEP_ON.
- active_o=1 in BEEP_ON, BEEP_OFF and PAUSE; 0 otherwise.
- Alert drop: alert_i=0 in any active state or SILENCED gives, next cycle:
  - IDLE;
  - buzzer_o=0;
  - beep_count_o=0;
  - phase and tone counters cleared.
  - No partial beep is completed.
- Ack: ack_i=1 in an active state with alert_i=1 gives, next cycle:
  - SILENCED;
  - buzzer_o=0; active_o=0; silenced_o=1;
  - beep_count_o=0.
- SILENCED:
  - Hold until alert_i=0, then IDLE with silenced_o=0.
  - A later alert re-arms from IDLE normally.
- Simultaneous events:
  - alert_i=0 together with ack_i=1: alert drop wins and the FSM goes to IDLE.
  - Phase expiry in the same cycle as ack or drop: ack/drop wins.
- Counters:
  - Phase counter is clog2(max(ON_CYCLES,OFF_CYCLES,PAUSE_CYCLES)) bits.
  - Tone counter is clog2(TONE_DIV) bits, minimum 1.
  - Both count down and reload on phase entry; neither wraps silently.
- Degenerate TONE_DIV >= ON_CYCLES: the beep is a single high level for ON_CYCLES cycles.

Optional Feature:
- Macro: ALARM_BEEPER_ESCALATE_EN.
- Defined:
  - A 3-bit saturating pattern counter increments on each PAUSE exit.
  - Once it reaches 4, BEEP_OFF and PAUSE are skipped: BEEP_ON repeats back-to-back, giving a continuous tone.
  - beep_count_o saturates at BURSTS.
  - The pattern counter clears on reset, IDLE and SILENCED.
- Undefined: the pattern repeats indefinitely unchanged; no counter is present.

Decomposition:
- Shared package alarm_pkg holds:
  - the state enum/encoding (3-bit, IDLE=0);
  - default timing constants;
  - the escalation threshold (4).
- One sub-module, beeper_tone_gen, with inputs clk, rst_n, en, restart and output tone.
  - It toggles every TONE_DIV cycles while en=1.
  - It is forced low when en=0.
  - It restarts high on restart.

Test Plan (defaults):
- Reset then alert_i rises:
  - buzzer_o=1 one edge later.
  - Tone pattern within the beep: 1,1,0,0,1,1,0,0.
  - active_o=1.
- Hold alert_i high for a full pattern:
  - Beeps at cycles 0–7, 16–23 and 32–39, each followed by 8 silent cycles; the third beep is followed by PAUSE instead.
  - beep_count_o reads 1, 2, 3.
  - PAUSE lasts 40–71.
  - beep_count_o returns to 0 and the next beep starts at 72.
- ack_i pulse at cycle 20:
  - At 21: buzzer_o=0, active_o=0, silenced_o=1.
  - Stays silent while alert_i is high.
  - Dropping alert_i gives IDLE; re-raising it restarts beeping.
- alert_i falls mid-beep (cycle 4):
  - Next cycle: buzzer_o=0, beep_count_o=0, IDLE.
- ack_i=1 in the same cycle alert_i=0: IDLE, silenced_o remains 0.
- Async reset asserted mid-PAUSE: all outputs 0 immediately, without waiting for a clk edge.
- With ALARM_BEEPER_ESCALATE_EN: after 4 patterns, buzzer_o toggles continuously with no 8-cycle gaps.
